// File: rtl/ldst_mmio_bridge.sv
// CPU load/store bridge: forwards RAM accesses and serves a small bank of
// memory-mapped peripheral registers, with a fixed 1-cycle read return.
module ldst_mmio_bridge #(
    parameter logic [15:0] RAM_TOP = 16'h7FFF,
    parameter int          SW_W    = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     i_ldst_addr,
    input  logic            i_ldst_rd,
    input  logic            i_ldst_wr,
    input  logic [15:0]     i_ldst_wrdata,
    output logic [15:0]     o_ldst_rddata,
    output logic [15:0]     o_ram_addr,
    output logic            o_ram_rd,
    output logic            o_ram_wr,
    output logic [15:0]     o_ram_wrdata,
    input  logic [15:0]     i_ram_rddata,
    input  logic [SW_W-1:0] i_sw,
    output logic [SW_W-1:0] o_ledr,
    output logic [15:0]     o_hex
);

    localparam logic [2:0] IDX_LEDR   = 3'd0;
    localparam logic [2:0] IDX_HEX    = 3'd1;
    localparam logic [2:0] IDX_SW     = 3'd2;
    localparam logic [2:0] IDX_CYCLES = 3'd3;
    localparam logic [2:0] IDX_TIMER  = 3'd4;
    localparam logic [2:0] IDX_TSTAT  = 3'd5;

    logic            ram_sel;
    logic            mmio_sel;
    logic            rd_req;
    logic            mmio_wr;
    logic [2:0]      reg_idx;
    logic            wr_ledr;
    logic            wr_hex;
    logic            wr_timer;
    logic            wr_tstat;
    logic [15:0]     mmio_rdata;

    logic [SW_W-1:0] ledr_reg;
    logic [15:0]     hex_reg;
    logic [15:0]     cycles_reg;
    logic [15:0]     timer_reg;
    logic [15:0]     timer_next;
    logic            expired_reg;
    logic            expired_next;
    logic            src_ram_reg;
    logic [15:0]     rddata_reg;

    // Addresses above RAM_TOP without bit 15 decode to nothing at all.
    assign ram_sel  = (i_ldst_addr <= RAM_TOP);
    assign mmio_sel = ~ram_sel & i_ldst_addr[15];
    assign rd_req   = i_ldst_rd & ~i_ldst_wr;
    assign mmio_wr  = i_ldst_wr & mmio_sel;
    assign reg_idx  = i_ldst_addr[3:1];

    assign wr_ledr  = mmio_wr && (reg_idx == IDX_LEDR);
    assign wr_hex   = mmio_wr && (reg_idx == IDX_HEX);
    assign wr_timer = mmio_wr && (reg_idx == IDX_TIMER);
    assign wr_tstat = mmio_wr && (reg_idx == IDX_TSTAT);

    assign o_ram_addr   = i_ldst_addr;
    assign o_ram_wrdata = i_ldst_wrdata;
    assign o_ram_rd     = rd_req & ram_sel;
    assign o_ram_wr     = i_ldst_wr & ram_sel;

    assign o_ledr        = ledr_reg;
    assign o_hex         = hex_reg;
    assign o_ldst_rddata = src_ram_reg ? i_ram_rddata : rddata_reg;

    always_comb begin
        mmio_rdata = '0;
        case (reg_idx)
            IDX_LEDR:   mmio_rdata[SW_W-1:0] = ledr_reg;
            IDX_HEX:    mmio_rdata = hex_reg;
            IDX_SW:     mmio_rdata[SW_W-1:0] = i_sw;
            IDX_CYCLES: mmio_rdata = cycles_reg;
            IDX_TIMER:  mmio_rdata = timer_reg;
            IDX_TSTAT:  mmio_rdata[0] = expired_reg;
            default:    mmio_rdata = '0;
        endcase
    end

    // A load overrides the decrement, so no expiry fires in a load cycle;
    // expiry is applied after the clear so it wins a same-cycle race.
    always_comb begin
        timer_next   = timer_reg;
        expired_next = expired_reg;
        if (wr_tstat && i_ldst_wrdata[0]) begin
            expired_next = 1'b0;
        end
        if (wr_timer) begin
            timer_next = i_ldst_wrdata;
        end else if (timer_reg != 16'd0) begin
            timer_next = timer_reg - 16'd1;
            if (timer_reg == 16'd1) begin
                expired_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ledr_reg    <= '0;
            hex_reg     <= '0;
            cycles_reg  <= '0;
            timer_reg   <= '0;
            expired_reg <= 1'b0;
            src_ram_reg <= 1'b0;
            rddata_reg  <= '0;
        end else begin
            cycles_reg  <= cycles_reg + 16'd1;
            timer_reg   <= timer_next;
            expired_reg <= expired_next;
            if (wr_ledr) begin
                ledr_reg <= i_ldst_wrdata[SW_W-1:0];
            end
            if (wr_hex) begin
                hex_reg <= i_ldst_wrdata;
            end
            // Capture the RAM word being returned so it holds once the
            // select drops back; a new non-RAM read replaces it.
            if (rd_req && !ram_sel) begin
                rddata_reg <= mmio_sel ? mmio_rdata : 16'h0000;
            end else if (src_ram_reg) begin
                rddata_reg <= i_ram_rddata;
            end
            src_ram_reg <= o_ram_rd;
        end
    end

endmodule

// File: tb/tb_ldst_mmio_bridge.sv
// Directed bench for ldst_mmio_bridge: a vector table for single-cycle
// accesses plus hand sequences for timer, counter and reset corner cases.
module tb_ldst_mmio_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_ldst_addr;
    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] i_ldst_wrdata;
    logic [15:0] o_ldst_rddata;
    logic [15:0] o_ram_addr;
    logic        o_ram_rd;
    logic        o_ram_wr;
    logic [15:0] o_ram_wrdata;
    logic [15:0] i_ram_rddata;
    logic [9:0]  i_sw;
    logic [9:0]  o_ledr;
    logic [15:0] o_hex;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    ldst_mmio_bridge #(.RAM_TOP(16'h7FFF), .SW_W(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_ldst_addr   (i_ldst_addr),
        .i_ldst_rd     (i_ldst_rd),
        .i_ldst_wr     (i_ldst_wr),
        .i_ldst_wrdata (i_ldst_wrdata),
        .o_ldst_rddata (o_ldst_rddata),
        .o_ram_addr    (o_ram_addr),
        .o_ram_rd      (o_ram_rd),
        .o_ram_wr      (o_ram_wr),
        .o_ram_wrdata  (o_ram_wrdata),
        .i_ram_rddata  (i_ram_rddata),
        .i_sw          (i_sw),
        .o_ledr        (o_ledr),
        .o_hex         (o_hex)
    );

    // 1-cycle-latency RAM model
    logic [15:0] ram_mem [0:255];
    logic [15:0] ram_q;
    always @(posedge clk) begin
        if (o_ram_wr) ram_mem[o_ram_addr[7:0]] <= o_ram_wrdata;
        if (o_ram_rd) ram_q <= ram_mem[o_ram_addr[7:0]];
    end
    assign i_ram_rddata = ram_q;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ram_rd;
        logic        ram_wr;
        logic [15:0] rdata;
        logic [9:0]  ledr;
        logic [15:0] hex;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        i_ldst_rd     = rd;
        i_ldst_wr     = wr;
        i_ldst_addr   = a;
        i_ldst_wrdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        set_in(1'b1, 1'b0, a, 16'h0000);
        tick();
        $display("read  addr=%h rddata=%h", a, o_ldst_rddata);
        check(name, o_ldst_rddata, exp);
    endtask

    task automatic wr_do(input logic [15:0] a, input logic [15:0] d);
        set_in(1'b0, 1'b1, a, d);
        tick();
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] c1;

        //            rd    wr    addr      wdata    ram_rd ram_wr rdata     ledr     hex
        vecs[0]  = '{1'b0, 1'b1, 16'h8000, 16'h02AB, 1'b0, 1'b0, 16'h0000, 10'h2AB, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h8002, 16'h1234, 1'b0, 1'b0, 16'h0000, 10'h2AB, 16'h1234};
        vecs[2]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h02AB, 10'h2AB, 16'h1234};
        vecs[3]  = '{1'b1, 1'b0, 16'h8002, 16'h0000, 1'b0, 1'b0, 16'h1234, 10'h2AB, 16'h1234};
        vecs[4]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 16'h1234, 10'h2AB, 16'h1234};
        vecs[5]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 10'h2AB, 16'h1234};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 10'h2AB, 16'h1234};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 10'h2AB, 16'h1234};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 10'h2AB, 16'h1234};
        vecs[9]  = '{1'b0, 1'b1, 16'h0011, 16'h0A5A, 1'b0, 1'b1, 16'hBEEF, 10'h2AB, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h0A5A, 10'h2AB, 16'h1234};
        vecs[11] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 1'b0, 1'b0, 16'h0155, 10'h2AB, 16'h1234};
        vecs[12] = '{1'b1, 1'b0, 16'h800E, 16'h0000, 1'b0, 1'b0, 16'h0000, 10'h2AB, 16'h1234};
        vecs[13] = '{1'b1, 1'b1, 16'h8002, 16'h5678, 1'b0, 1'b0, 16'h0000, 10'h2AB, 16'h5678};
        vecs[14] = '{1'b1, 1'b0, 16'h8002, 16'h0000, 1'b0, 1'b0, 16'h5678, 10'h2AB, 16'h5678};
        vecs[15] = '{1'b0, 1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h5678, 10'h3FF, 16'h5678};
        vecs[16] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h03FF, 10'h3FF, 16'h5678};
        vecs[17] = '{1'b1, 1'b1, 16'h0012, 16'h1111, 1'b0, 1'b1, 16'h03FF, 10'h3FF, 16'h5678};
        vecs[18] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b0, 16'h1111, 10'h3FF, 16'h5678};
        vecs[19] = '{1'b1, 1'b0, 16'h800C, 16'h0000, 1'b0, 1'b0, 16'h0000, 10'h3FF, 16'h5678};
        vecs[20] = '{1'b0, 1'b1, 16'h800C, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 10'h3FF, 16'h5678};
        vecs[21] = '{1'b1, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h03FF, 10'h3FF, 16'h5678};

        reset         = 1'b1;
        i_sw          = 10'h155;
        i_ldst_rd     = 1'b0;
        i_ldst_wr     = 1'b0;
        i_ldst_addr   = 16'h0000;
        i_ldst_wrdata = 16'h0000;
        tick();
        tick();
        check("reset_rddata", o_ldst_rddata, 16'h0000);
        check("reset_ledr", {6'd0, o_ledr}, 16'h0000);
        check("reset_hex", o_hex, 16'h0000);

        // First cycle out of reset: the counter still reads 0.
        set_in(1'b1, 1'b0, 16'h8006, 16'h0000);
        reset = 1'b0;
        tick();
        check("cycles_after_reset", o_ldst_rddata, 16'h0000);

        for (int i = 0; i < NVEC; i++) begin
            set_in(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("v%0d_ram_rd", i), {15'd0, o_ram_rd}, {15'd0, vecs[i].ram_rd});
            check($sformatf("v%0d_ram_wr", i), {15'd0, o_ram_wr}, {15'd0, vecs[i].ram_wr});
            check($sformatf("v%0d_ram_addr", i), o_ram_addr, vecs[i].addr);
            tick();
            $display("vec %0d rd=%b wr=%b addr=%h wdata=%h -> rddata=%h ledr=%h hex=%h",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     o_ldst_rddata, o_ledr, o_hex);
            check($sformatf("v%0d_rddata", i), o_ldst_rddata, vecs[i].rdata);
            check($sformatf("v%0d_ledr", i), {6'd0, o_ledr}, {6'd0, vecs[i].ledr});
            check($sformatf("v%0d_hex", i), o_hex, vecs[i].hex);
        end

        // Timer countdown, sticky expiry, clear.
        wr_do(16'h8008, 16'd3);
        rd_check("timer_3", 16'h8008, 16'd3);
        rd_check("timer_2", 16'h8008, 16'd2);
        rd_check("timer_1", 16'h8008, 16'd1);
        rd_check("timer_0", 16'h8008, 16'd0);
        rd_check("tstat_expired", 16'h800A, 16'h0001);
        rd_check("tstat_sticky", 16'h800A, 16'h0001);
        wr_do(16'h800A, 16'h0001);
        rd_check("tstat_cleared", 16'h800A, 16'h0000);

        // Expiry and clear in the same cycle: expiry wins.
        wr_do(16'h8008, 16'd1);
        wr_do(16'h800A, 16'h0001);
        rd_check("tstat_expiry_wins", 16'h800A, 16'h0001);
        wr_do(16'h800A, 16'h0001);

        // Writing 0 stops the timer without flagging expiry.
        wr_do(16'h8008, 16'd3);
        wr_do(16'h8008, 16'd0);
        idle();
        idle();
        idle();
        rd_check("timer_stopped", 16'h8008, 16'd0);
        rd_check("tstat_after_stop", 16'h800A, 16'h0000);

        // Cycle counter: reads five cycles apart differ by 5.
        set_in(1'b1, 1'b0, 16'h8006, 16'h0000);
        tick();
        c1 = o_ldst_rddata;
        idle();
        idle();
        idle();
        idle();
        set_in(1'b1, 1'b0, 16'h8006, 16'h0000);
        tick();
        $display("cycles c1=%h c2=%h", c1, o_ldst_rddata);
        check("cycles_delta", o_ldst_rddata - c1, 16'd5);

        // Wrap: preset the counter to 0xFFFF just before a read.
        set_in(1'b1, 1'b0, 16'h8006, 16'h0000);
        force dut.cycles_reg = 16'hFFFF;
        #1;
        release dut.cycles_reg;
        tick();
        check("cycles_ffff", o_ldst_rddata, 16'hFFFF);
        rd_check("cycles_wrap", 16'h8006, 16'h0000);

        // Reset mid-countdown, with expired set, and over a pending RAM read.
        wr_do(16'h8008, 16'd1);
        idle();
        wr_do(16'h8008, 16'd5);
        idle();
        rd_check("pre_reset_rddata", 16'h8002, 16'h5678);
        set_in(1'b1, 1'b0, 16'h0010, 16'h0000);
        reset = 1'b1;
        #1;
        check("ram_rd_in_reset", {15'd0, o_ram_rd}, 16'h0001);
        tick();
        $display("reset mid-read rddata=%h ledr=%h hex=%h", o_ldst_rddata, o_ledr, o_hex);
        check("reset_return_rddata", o_ldst_rddata, 16'h0000);
        check("reset2_ledr", {6'd0, o_ledr}, 16'h0000);
        check("reset2_hex", o_hex, 16'h0000);
        set_in(1'b1, 1'b0, 16'h8006, 16'h0000);
        reset = 1'b0;
        tick();
        check("reset2_cycles", o_ldst_rddata, 16'h0000);
        rd_check("reset2_timer", 16'h8008, 16'h0000);
        rd_check("reset2_tstat", 16'h800A, 16'h0000);
        idle();
        rd_check("reset2_timer_idle", 16'h8008, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
